// File: rtl/serial_frame_deserializer.sv
// Serial frame deserializer: frames start/data/[parity]/stop, LSB-first,
// with a valid/ready holding register and one-cycle error pulses.
//
// Ports:
//   clk, reset (async, active-low)
//   serial_in, bit_en        : bitstream and its sample strobe
//   data_out, data_valid     : holding register and its full flag
//   data_ready               : consumer accept
//   busy                     : FSM not in IDLE
//   frame_err, overrun,
//   parity_err               : one-cycle error pulses
// Optional feature macro: PARITY_CHECK_EN (adds even-parity check state).

module serial_frame_deserializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              parity_err_q, parity_err_d;

  logic last_bit;
  logic stop_smp;
  logic par_bad;
  logic good;
  logic accept;
  logic load;

  assign last_bit = (cnt_q == CW'(DATA_W - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (serial_in) state_d = DATA;
        end
        DATA: begin
          if (last_bit) begin
`ifdef PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
        PARITY: state_d = STOP;
        STOP:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef PARITY_CHECK_EN
  logic par_q, par_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  always_comb begin
    par_d = par_q;
    if (bit_en && state_q == PARITY) par_d = serial_in;
  end

  // Even parity: the parity bit must equal the XOR of the data bits.
  assign par_bad = (par_q != ^shift_q);
`else
  assign par_bad = 1'b0;
`endif

  // Output and datapath logic
  always_comb begin
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    valid_d      = valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    parity_err_d = 1'b0;

    stop_smp = bit_en && (state_q == STOP);
    good     = stop_smp && !serial_in && !par_bad;
    accept   = valid_q && data_ready;
    // A full register can still load if it is drained on the same edge.
    load     = good && (!valid_q || accept);

    if (bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (serial_in) cnt_d = '0;
        end
        DATA: begin
          shift_d[cnt_q] = serial_in;
          cnt_d          = cnt_q + 1'b1;
        end
        default: ;
      endcase
    end

    if (load) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end

    frame_err_d  = stop_smp && serial_in;
    parity_err_d = stop_smp && par_bad;
    overrun_d    = good && !load;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q      <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = (state_q != IDLE);
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Testbench for serial_frame_deserializer (DATA_W = 8).
// Build with or without PARITY_CHECK_EN to match the RTL.

module tb_serial_frame_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         serial_in = 1'b0;
  logic         bit_en = 1'b0;
  logic         data_ready = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         frame_err;
  logic         overrun;
  logic         parity_err;

  int n_cmp = 0;
  int n_err = 0;
  int gap = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;

  always #5 clk = ~clk;

  serial_frame_deserializer #(.DATA_W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .bit_en     (bit_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    for (int i = 0; i < gap; i++) begin
      bit_en = 1'b0;
      tick();
    end
    serial_in = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    serial_in = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic stop_b,
                            input logic pflip, input logic rdy);
    data_ready = 1'b0;
    send_bit(1'b1);
    for (int i = 0; i < W; i++) send_bit(w[i]);
`ifdef PARITY_CHECK_EN
    send_bit((^w) ^ pflip);
`endif
    data_ready = rdy;
    send_bit(stop_b);
    data_ready = 1'b0;
  endtask

  // Pop the scoreboard and compare against the holding register.
  task automatic pop_check(input string tag);
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s_sb: scoreboard empty, data_out=%h", tag, data_out);
    end else begin
      exp_w = exp_q.pop_front();
      if (data_valid !== 1'b1 || data_out !== exp_w) begin
        n_err++;
        $display("FAIL %s_word: got v=%b %h want v=1 %h",
                 tag, data_valid, data_out, exp_w);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({data_out, data_valid, busy, frame_err, overrun, parity_err} !== '0) begin
      n_err++;
      $display("FAIL reset_outs: got %h %b%b%b%b%b want all 0", data_out,
               data_valid, busy, frame_err, overrun, parity_err);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    pop_check("basic");
    n_cmp++;
    if (busy !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0) begin
      n_err++;
      $display("FAIL basic_flags: got busy=%b fe=%b pe=%b want 0 0 0",
               busy, frame_err, parity_err);
    end
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    n_cmp++;
    if (data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_drain: got valid=%b want 0", data_valid);
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (frame_err !== 1'b1 || data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ferr_pulse: got fe=%b v=%b want fe=1 v=0",
               frame_err, data_valid);
    end
    tick();
    n_cmp++;
    if (frame_err !== 1'b0 || data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ferr_end: got fe=%b v=%b want 0 0", frame_err, data_valid);
    end
  endtask

  task automatic test_overrun();
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (data_valid !== 1'b1 || data_out !== 8'h3C) begin
      n_err++;
      $display("FAIL ovr_first: got v=%b %h want 1 3c", data_valid, data_out);
    end
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (overrun !== 1'b1 || data_out !== 8'h3C) begin
      n_err++;
      $display("FAIL ovr_pulse: got ovr=%b %h want 1 3c", overrun, data_out);
    end
    tick();
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_end: got ovr=%b want 0", overrun);
    end
    pop_check("ovr_hold");
  endtask

  task automatic test_accept_load();
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    pop_check("accld");
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL accld_ovr: got ovr=%b want 0", overrun);
    end
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    n_cmp++;
    if (data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL accld_drain: got valid=%b want 0", data_valid);
    end
  endtask

  task automatic test_reset_mid();
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    pop_check("rstmid_pre");
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_busy: got busy=%b want 1", busy);
    end
    bit_en = 1'b1;
    serial_in = 1'b1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({data_out, data_valid, busy, frame_err, overrun, parity_err} !== '0) begin
      n_err++;
      $display("FAIL rstmid_outs: got %h %b%b%b%b%b want all 0", data_out,
               data_valid, busy, frame_err, overrun, parity_err);
    end
    tick();
    bit_en = 1'b0;
    serial_in = 1'b0;
    reset = 1'b1;
    tick();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    pop_check("rstmid_post");
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  task automatic test_gap();
    gap = 2;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    gap = 0;
    pop_check("gap");
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    n_cmp++;
    if (data_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL gap_end: got v=%b busy=%b want 0 0", data_valid, busy);
    end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (parity_err !== 1'b1 || data_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL par_bad: got pe=%b v=%b fe=%b want 1 0 0",
               parity_err, data_valid, frame_err);
    end
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (parity_err !== 1'b0) begin
      n_err++;
      $display("FAIL par_ok_pe: got pe=%b want 0", parity_err);
    end
    pop_check("par_ok");
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (parity_err !== 1'b1 || frame_err !== 1'b1 || data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL par_both: got pe=%b fe=%b v=%b want 1 1 0",
               parity_err, frame_err, data_valid);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_frame_err();
    test_overrun();
    test_accept_load();
    test_reset_mid();
    test_gap();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
